load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_AW, 8, word-address width of the data memory port.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  core issues an access.
REQ-005 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port: is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: signed_unsigned  input  1  0 = sign-extend load, 1 = zero-extend load.
REQ-008 SHALL have port: mem_size  input  2  01 = byte, 10 = half, 11 = word, 00 = illegal.
REQ-009 SHALL have port: addr  input  32  byte address.
REQ-010 SHALL have port: wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: rdata  output  32  formatted load result.
REQ-013 SHALL have port: err  output  1  access rejected; qualified by resp_valid.
REQ-014 SHALL have port: mem_addr  output  MEM_AW  word address, equal to addr[MEM_AW+1:2].
REQ-015 SHALL have port: mem_read  output  1  memory read strobe.
REQ-016 SHALL have port: mem_write  output  1  memory write strobe.
REQ-017 SHALL have port: mem_wdata  output  32  full word to write.
REQ-018 SHALL have port: mem_rdata  input  32  word read; valid the cycle after a mem_read cycle.

Function
REQ-019 SHALL implement states IDLE, RD, WAIT, WR, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL capture is_store, signed_unsigned, mem_size, addr and wdata on the edge where req_valid and req_ready are both high.
REQ-021 SHALL transition from IDLE on accept to: RD for a load or sub-word store; WR for a word store; RESP with err = 1 for mem_size 00 or a rejected misaligned access.
REQ-022 SHALL assert mem_read only in RD, advance RD -> WAIT, and register mem_rdata in WAIT.
REQ-023 SHALL, in WAIT for a load, select byte addr[1:0] or half addr[1], extend it per signed_unsigned into rdata, then go to RESP.
REQ-024 SHALL, in WAIT for a sub-word store, merge wdata[7:0]/[15:0] into the selected lane of the read word, leave other lanes unchanged, then go to WR.
REQ-025 SHALL assert mem_write with mem_wdata only in WR, then go to RESP.
REQ-026 SHALL assert resp_valid for exactly one cycle in RESP and return to IDLE; the response has no backpressure.
REQ-027 SHALL meet these latencies from the accept edge to resp_valid high: load = 3 cycles, word store = 2, sub-word store = 4, error = 1.
REQ-028 SHALL hold rdata stable from RESP until the next load completes; rdata is undefined-free (0) for stores and errors.
REQ-029 SHALL never assert mem_read and mem_write in the same cycle.
REQ-030 SHALL ignore addr bits above MEM_AW+1.

Reset
REQ-031 SHALL on reset set state to IDLE and set rdata = 0, err = 0, resp_valid = 0, mem_read = 0 and mem_write = 0; req_ready = 1 the cycle after reset.
REQ-032 SHALL abort any in-flight access on reset without issuing a response; a WR-state write coinciding with the reset edge still reaches memory.

Configuration
REQ-033 SHALL use macro MISALIGN_TRAP_EN: when defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 completes with err = 1 and no memory strobe.
REQ-034 SHALL, without MISALIGN_TRAP_EN, force the offending low address bits to 0 and perform the access normally with err = 0.

Verification
REQ-035 SHALL verify: memory word 4 = 0x8899AABB; signed byte load at addr 0x13 -> rdata 0xFFFFFF88, resp_valid 3 cycles after accept.
REQ-036 SHALL verify: same word; unsigned half load at addr 0x12 -> rdata 0x00008899.
REQ-037 SHALL verify: same word; byte store 0x5A at addr 0x11 -> mem_write with mem_wdata 0x88995ABB, resp_valid 4 cycles after accept.
REQ-038 SHALL verify: half load at addr 0x13 -> with MISALIGN_TRAP_EN, err = 1 after 1 cycle and mem_read never asserted; without it, rdata 0xFFFF8899.
REQ-039 SHALL verify: mem_size 00 -> err = 1, no strobes; reset asserted in RD -> no resp_valid, req_ready = 1 the cycle after reset.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: sub-word loads with sign/zero extension and read-modify-write sub-word stores
// over a word-wide memory port. Optional macro MISALIGN_TRAP_EN rejects misaligned accesses.
module load_store_unit #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic              signed_unsigned,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_is_store;
    logic               r_zext;
    logic [1:0]         r_size;
    logic [1:0]         r_addr_lo;
    logic [MEM_AW-1:0]  r_word_addr;
    logic [15:0]        r_wdata_lo;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic               w_accept;
    logic               w_reject;
    logic [1:0]         w_lo;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_data;
    logic [31:0]        w_merged;
    logic               w_unused_addr;

    assign w_accept      = req_valid && req_ready;
    assign w_unused_addr = ^addr[31:MEM_AW+2];

`ifdef MISALIGN_TRAP_EN
    assign w_reject = (mem_size == 2'b00)
                   || (mem_size == 2'b10 && addr[0])
                   || (mem_size == 2'b11 && addr[1:0] != 2'b00);
`else
    assign w_reject = (mem_size == 2'b00);
`endif

    // Misaligned halves/words are realigned down; only matters when the trap is disabled.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_lo = addr[1:0];
        case (mem_size)
            2'b10:   w_lo = {addr[1], 1'b0};
            2'b11:   w_lo = 2'b00;
            default: ;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) begin
                if (w_reject)                          w_next = RESP;
                else if (is_store && mem_size == 2'b11) w_next = WR;
                else                                    w_next = RD;
            end
            RD:      w_next = WAIT;
            WAIT:    w_next = r_is_store ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == IDLE);
        mem_read   = (r_state == RD);
        mem_write  = (r_state == WR);
        resp_valid = (r_state == RESP);
        err        = (r_state == RESP) && r_err;
    end

    always_comb begin
        w_byte = mem_rdata[{r_addr_lo, 3'b000} +: 8];
        w_half = mem_rdata[{r_addr_lo[1], 4'b0000} +: 16];
        case (r_size)
            2'b01:   w_load_data = r_zext ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b10:   w_load_data = r_zext ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = mem_rdata;
        endcase
        w_merged = mem_rdata;
        case (r_size)
            2'b01:   w_merged[{r_addr_lo, 3'b000} +: 8]     = r_wdata_lo[7:0];
            2'b10:   w_merged[{r_addr_lo[1], 4'b0000} +: 16] = r_wdata_lo;
            default: ;
        endcase
    end

    // rdata holds the last load result; stores and rejected accesses complete with 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_reject;
            if (w_reject) r_rdata <= '0;
        end else if (r_state == WAIT && !r_is_store) begin
            r_rdata <= w_load_data;
        end else if (r_state == WR) begin
            r_rdata <= '0;
        end
    end

    // NOTE: request/datapath registers carry no reset; they are only read after an accept loads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_store  <= is_store;
            r_zext      <= signed_unsigned;
            r_size      <= mem_size;
            r_addr_lo   <= w_lo;
            r_word_addr <= addr[MEM_AW+1:2];
            r_wdata_lo  <= wdata[15:0];
            r_mem_wdata <= wdata;
        end else if (r_state == WAIT) begin
            r_mem_wdata <= w_merged;
        end
    end

    assign rdata     = r_rdata;
    assign mem_addr  = r_word_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
